axi_outstanding_limiter: RTL and testbench

Sits directly upstream of the AXI pipeline stage, between the kernel's m_axi master and the pipeline's "in" side.
- Caps outstanding read and write bursts so the relay-station pipeline plus memory never hold more than a fixed number of transactions per direction.
- Gates W beats so no write data enters the pipeline before its AW has been accepted.
- Zero-latency on all paths; the only state is counters.

---
 rtl/axi_pipe_pkg.sv | 23 ++
 rtl/outstanding_counter.sv | 42 ++++
 rtl/axi_outstanding_limiter.sv | 173 +++++++++++++++++
 tb/tb_axi_outstanding_limiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pipe_pkg.sv
// Shared AXI pipeline definitions: default widths, packed payload widths and burst encodings.
package axi_pipe_pkg;

  localparam int AXI_ID_WIDTH    = 1;
  localparam int AXI_ADDR_WIDTH  = 32;
  localparam int AXI_DATA_WIDTH  = 512;
  localparam int AXI_WSTRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int AXI_CNT_WIDTH   = 8;

  // Packed payload widths, shared with the relay-station pipeline stage.
  localparam int AXI_AX_PAYLOAD_W = AXI_ADDR_WIDTH + 2 + 8 + 3 + AXI_ID_WIDTH;
  localparam int AXI_W_PAYLOAD_W  = AXI_DATA_WIDTH + AXI_WSTRB_WIDTH + 1;
  localparam int AXI_R_PAYLOAD_W  = AXI_DATA_WIDTH + 1 + AXI_ID_WIDTH + 2;
  localparam int AXI_B_PAYLOAD_W  = 2 + AXI_ID_WIDTH;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // Counter slots inside the limiter.
  localparam int CNT_IDX_RD = 0;
  localparam int CNT_IDX_WR = 1;
  localparam int CNT_IDX_WC = 2;

endpackage

// File: rtl/outstanding_counter.sv
// Saturating up/down counter with limit compare; simultaneous inc and dec leaves it unchanged.
module outstanding_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             below_limit,
  output logic             nonzero,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] LIMIT_CNT = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;

  always_comb begin
    cnt_next  = cnt_reg;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (cnt_reg != '1) cnt_next = cnt_reg + WIDTH'(1);
    end else if (dec && !inc) begin
      // A decrement at zero is a lost response: hold at zero and flag it.
      if (cnt_reg == '0) underflow = 1'b1;
      else               cnt_next  = cnt_reg - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) cnt_reg <= '0;
    else      cnt_reg <= cnt_next;
  end

  assign cnt         = cnt_reg;
  assign below_limit = (cnt_reg < LIMIT_CNT);
  assign nonzero     = (cnt_reg != '0);

endmodule

// File: rtl/axi_outstanding_limiter.sv
// Zero-latency AXI front end that caps outstanding read/write bursts and holds W until its AW is accepted.
module axi_outstanding_limiter
  import axi_pipe_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH    = AXI_ID_WIDTH,
  parameter int C_M_AXI_ADDR_WIDTH  = AXI_ADDR_WIDTH,
  parameter int C_M_AXI_DATA_WIDTH  = AXI_DATA_WIDTH,
  parameter int C_M_AXI_WSTRB_WIDTH = AXI_WSTRB_WIDTH,
  parameter int MAX_RD_OUTSTANDING  = 16,
  parameter int MAX_WR_OUTSTANDING  = 16,
  parameter int CNT_WIDTH           = AXI_CNT_WIDTH
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  // kernel side
  input  logic                           s_AWVALID,
  output logic                           s_AWREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  s_AWADDR,
  input  logic [1:0]                     s_AWBURST,
  input  logic [7:0]                     s_AWLEN,
  input  logic [2:0]                     s_AWSIZE,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    s_AWID,
  input  logic                           s_WVALID,
  output logic                           s_WREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  s_WDATA,
  input  logic [C_M_AXI_WSTRB_WIDTH-1:0] s_WSTRB,
  input  logic                           s_WLAST,
  output logic                           s_BVALID,
  input  logic                           s_BREADY,
  output logic [1:0]                     s_BRESP,
  output logic [C_M_AXI_ID_WIDTH-1:0]    s_BID,
  input  logic                           s_ARVALID,
  output logic                           s_ARREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  s_ARADDR,
  input  logic [1:0]                     s_ARBURST,
  input  logic [7:0]                     s_ARLEN,
  input  logic [2:0]                     s_ARSIZE,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    s_ARID,
  output logic                           s_RVALID,
  input  logic                           s_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  s_RDATA,
  output logic                           s_RLAST,
  output logic [C_M_AXI_ID_WIDTH-1:0]    s_RID,
  output logic [1:0]                     s_RRESP,
  // pipeline side
  output logic                           m_AWVALID,
  input  logic                           m_AWREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  m_AWADDR,
  output logic [1:0]                     m_AWBURST,
  output logic [7:0]                     m_AWLEN,
  output logic [2:0]                     m_AWSIZE,
  output logic [C_M_AXI_ID_WIDTH-1:0]    m_AWID,
  output logic                           m_WVALID,
  input  logic                           m_WREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  m_WDATA,
  output logic [C_M_AXI_WSTRB_WIDTH-1:0] m_WSTRB,
  output logic                           m_WLAST,
  input  logic                           m_BVALID,
  output logic                           m_BREADY,
  input  logic [1:0]                     m_BRESP,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    m_BID,
  output logic                           m_ARVALID,
  input  logic                           m_ARREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  m_ARADDR,
  output logic [1:0]                     m_ARBURST,
  output logic [7:0]                     m_ARLEN,
  output logic [2:0]                     m_ARSIZE,
  output logic [C_M_AXI_ID_WIDTH-1:0]    m_ARID,
  input  logic                           m_RVALID,
  output logic                           m_RREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  m_RDATA,
  input  logic                           m_RLAST,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    m_RID,
  input  logic [1:0]                     m_RRESP,
  // status
  output logic [CNT_WIDTH-1:0]           rd_outstanding,
  output logic [CNT_WIDTH-1:0]           wr_outstanding,
  output logic                           err_underflow
);

  logic [2:0]           cnt_inc;
  logic [2:0]           cnt_dec;
  logic [2:0]           cnt_below;
  logic [2:0]           cnt_nonzero;
  logic [2:0]           cnt_uflow;
  logic [CNT_WIDTH-1:0] cnt_val [3];
  logic                 err_underflow_reg;
  logic                 unused_flags;

  logic ar_ok, aw_ok, w_ok;
  logic ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;

  // Gates use registered counts only, so VALID never depends on READY.
  assign ar_ok = cnt_below[CNT_IDX_RD]   & ~ap_rst;
  assign aw_ok = cnt_below[CNT_IDX_WR]   & ~ap_rst;
  assign w_ok  = cnt_nonzero[CNT_IDX_WC] & ~ap_rst;

  assign m_ARVALID = s_ARVALID & ar_ok;
  assign s_ARREADY = m_ARREADY & ar_ok;
  assign m_AWVALID = s_AWVALID & aw_ok;
  assign s_AWREADY = m_AWREADY & aw_ok;
  assign m_WVALID  = s_WVALID  & w_ok;
  assign s_WREADY  = m_WREADY  & w_ok;

  assign m_AWADDR  = s_AWADDR;
  assign m_AWBURST = s_AWBURST;
  assign m_AWLEN   = s_AWLEN;
  assign m_AWSIZE  = s_AWSIZE;
  assign m_AWID    = s_AWID;
  assign m_WDATA   = s_WDATA;
  assign m_WSTRB   = s_WSTRB;
  assign m_WLAST   = s_WLAST;
  assign m_ARADDR  = s_ARADDR;
  assign m_ARBURST = s_ARBURST;
  assign m_ARLEN   = s_ARLEN;
  assign m_ARSIZE  = s_ARSIZE;
  assign m_ARID    = s_ARID;

  assign s_BVALID  = m_BVALID;
  assign m_BREADY  = s_BREADY;
  assign s_BRESP   = m_BRESP;
  assign s_BID     = m_BID;
  assign s_RVALID  = m_RVALID;
  assign m_RREADY  = s_RREADY;
  assign s_RDATA   = m_RDATA;
  assign s_RLAST   = m_RLAST;
  assign s_RID     = m_RID;
  assign s_RRESP   = m_RRESP;

  assign ar_hs     = m_ARVALID & m_ARREADY;
  assign aw_hs     = m_AWVALID & m_AWREADY;
  assign w_last_hs = m_WVALID & m_WREADY & m_WLAST;
  assign r_last_hs = m_RVALID & s_RREADY & m_RLAST;
  assign b_hs      = m_BVALID & s_BREADY;

  assign cnt_inc[CNT_IDX_RD] = ar_hs;
  assign cnt_dec[CNT_IDX_RD] = r_last_hs;
  assign cnt_inc[CNT_IDX_WR] = aw_hs;
  assign cnt_dec[CNT_IDX_WR] = b_hs;
  assign cnt_inc[CNT_IDX_WC] = aw_hs;
  assign cnt_dec[CNT_IDX_WC] = w_last_hs;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      outstanding_counter #(
        .WIDTH (CNT_WIDTH),
        .LIMIT ((gi == CNT_IDX_RD) ? MAX_RD_OUTSTANDING : MAX_WR_OUTSTANDING)
      ) u_cnt (
        .clk         (ap_clk),
        .srst        (ap_rst),
        .inc         (cnt_inc[gi]),
        .dec         (cnt_dec[gi]),
        .cnt         (cnt_val[gi]),
        .below_limit (cnt_below[gi]),
        .nonzero     (cnt_nonzero[gi]),
        .underflow   (cnt_uflow[gi])
      );
    end
  endgenerate

  always_ff @(posedge ap_clk) begin
    if (ap_rst)          err_underflow_reg <= 1'b0;
    else if (|cnt_uflow) err_underflow_reg <= 1'b1;
  end

  assign rd_outstanding = cnt_val[CNT_IDX_RD];
  assign wr_outstanding = cnt_val[CNT_IDX_WR];
  assign err_underflow  = err_underflow_reg;

  assign unused_flags = &{1'b0, cnt_nonzero[CNT_IDX_RD], cnt_nonzero[CNT_IDX_WR],
                          cnt_below[CNT_IDX_WC]};

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Directed bench for axi_outstanding_limiter with limits of 4 reads / 4 writes.
module tb_axi_outstanding_limiter;

  localparam int IDW = 1;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int CW  = 8;

  logic ap_clk = 1'b0;
  logic ap_rst;

  logic s_AWVALID, s_AWREADY; logic [AW-1:0] s_AWADDR; logic [1:0] s_AWBURST;
  logic [7:0] s_AWLEN; logic [2:0] s_AWSIZE; logic [IDW-1:0] s_AWID;
  logic s_WVALID, s_WREADY; logic [DW-1:0] s_WDATA; logic [SW-1:0] s_WSTRB; logic s_WLAST;
  logic s_BVALID, s_BREADY; logic [1:0] s_BRESP; logic [IDW-1:0] s_BID;
  logic s_ARVALID, s_ARREADY; logic [AW-1:0] s_ARADDR; logic [1:0] s_ARBURST;
  logic [7:0] s_ARLEN; logic [2:0] s_ARSIZE; logic [IDW-1:0] s_ARID;
  logic s_RVALID, s_RREADY; logic [DW-1:0] s_RDATA; logic s_RLAST;
  logic [IDW-1:0] s_RID; logic [1:0] s_RRESP;

  logic m_AWVALID, m_AWREADY; logic [AW-1:0] m_AWADDR; logic [1:0] m_AWBURST;
  logic [7:0] m_AWLEN; logic [2:0] m_AWSIZE; logic [IDW-1:0] m_AWID;
  logic m_WVALID, m_WREADY; logic [DW-1:0] m_WDATA; logic [SW-1:0] m_WSTRB; logic m_WLAST;
  logic m_BVALID, m_BREADY; logic [1:0] m_BRESP; logic [IDW-1:0] m_BID;
  logic m_ARVALID, m_ARREADY; logic [AW-1:0] m_ARADDR; logic [1:0] m_ARBURST;
  logic [7:0] m_ARLEN; logic [2:0] m_ARSIZE; logic [IDW-1:0] m_ARID;
  logic m_RVALID, m_RREADY; logic [DW-1:0] m_RDATA; logic m_RLAST;
  logic [IDW-1:0] m_RID; logic [1:0] m_RRESP;

  logic [CW-1:0] rd_outstanding, wr_outstanding;
  logic          err_underflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  axi_outstanding_limiter #(
    .C_M_AXI_ID_WIDTH(IDW), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_WSTRB_WIDTH(SW), .MAX_RD_OUTSTANDING(4), .MAX_WR_OUTSTANDING(4),
    .CNT_WIDTH(CW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR), .s_AWBURST(s_AWBURST),
    .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE), .s_AWID(s_AWID),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST),
    .s_BVALID(s_BVALID), .s_BREADY(s_BREADY), .s_BRESP(s_BRESP), .s_BID(s_BID),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARBURST(s_ARBURST),
    .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE), .s_ARID(s_ARID),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RLAST(s_RLAST),
    .s_RID(s_RID), .s_RRESP(s_RRESP),
    .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY), .m_AWADDR(m_AWADDR), .m_AWBURST(m_AWBURST),
    .m_AWLEN(m_AWLEN), .m_AWSIZE(m_AWSIZE), .m_AWID(m_AWID),
    .m_WVALID(m_WVALID), .m_WREADY(m_WREADY), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WLAST(m_WLAST),
    .m_BVALID(m_BVALID), .m_BREADY(m_BREADY), .m_BRESP(m_BRESP), .m_BID(m_BID),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR), .m_ARBURST(m_ARBURST),
    .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE), .m_ARID(m_ARID),
    .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA), .m_RLAST(m_RLAST),
    .m_RID(m_RID), .m_RRESP(m_RRESP),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .err_underflow(err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check_gated(input string tag);
    check({tag, " m_ARVALID"}, 32'(m_ARVALID), 32'd0);
    check({tag, " s_ARREADY"}, 32'(s_ARREADY), 32'd0);
    check({tag, " m_AWVALID"}, 32'(m_AWVALID), 32'd0);
    check({tag, " s_AWREADY"}, 32'(s_AWREADY), 32'd0);
    check({tag, " m_WVALID"},  32'(m_WVALID),  32'd0);
    check({tag, " s_WREADY"},  32'(s_WREADY),  32'd0);
  endtask

  initial begin
    ap_rst = 1'b1;
    s_AWVALID = 1'b1; s_AWADDR = 32'h2000_0000; s_AWBURST = 2'b01; s_AWLEN = 8'd0;
    s_AWSIZE = 3'd2; s_AWID = '0;
    s_WVALID = 1'b1; s_WDATA = 32'h5555_AAAA; s_WSTRB = 4'hF; s_WLAST = 1'b0;
    s_BREADY = 1'b1;
    s_ARVALID = 1'b1; s_ARADDR = 32'h1000_0040; s_ARBURST = 2'b01; s_ARLEN = 8'd0;
    s_ARSIZE = 3'd2; s_ARID = '0;
    s_RREADY = 1'b1;
    m_AWREADY = 1'b1; m_WREADY = 1'b1; m_ARREADY = 1'b1;
    m_BVALID = 1'b0; m_BRESP = 2'b00; m_BID = '0;
    m_RVALID = 1'b0; m_RDATA = 32'hCAFE_0001; m_RLAST = 1'b0; m_RID = '0; m_RRESP = 2'b00;

    // reset: gating and cleared state
    #2;
    check_gated("rst0");
    cyc();
    check("rst0 rd_outstanding", 32'(rd_outstanding), 32'd0);
    check("rst0 wr_outstanding", 32'(wr_outstanding), 32'd0);
    check("rst0 err_underflow",  32'(err_underflow),  32'd0);
    ap_rst = 1'b0; s_ARVALID = 1'b0; s_AWVALID = 1'b0; s_WVALID = 1'b0;
    cyc();

    // six back-to-back ARs against a limit of four
    s_ARVALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("ar%0d s_ARREADY", i), 32'(s_ARREADY), (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("ar%0d m_ARVALID", i), 32'(m_ARVALID), (i < 4) ? 32'd1 : 32'd0);
      cyc();
    end
    check("ar full rd_outstanding", 32'(rd_outstanding), 32'd4);
    check("ar m_ARADDR passthru", m_ARADDR, 32'h1000_0040);

    // RLAST at full: AR stays closed this cycle, reopens next
    m_RVALID = 1'b1; m_RLAST = 1'b1;
    #1;
    check("full+rlast s_ARREADY", 32'(s_ARREADY), 32'd0);
    check("full+rlast m_ARVALID", 32'(m_ARVALID), 32'd0);
    check("r s_RVALID passthru", 32'(s_RVALID), 32'd1);
    check("r s_RDATA passthru", s_RDATA, 32'hCAFE_0001);
    cyc();
    check("after rlast rd_outstanding", 32'(rd_outstanding), 32'd3);
    m_RVALID = 1'b0;
    #1;
    check("reopen s_ARREADY", 32'(s_ARREADY), 32'd1);
    cyc();
    check("refill rd_outstanding", 32'(rd_outstanding), 32'd4);
    s_ARVALID = 1'b0;

    // non-last R beat leaves count alone, then drain with RLASTs
    m_RVALID = 1'b1; m_RLAST = 1'b0;
    cyc();
    check("r nonlast rd_outstanding", 32'(rd_outstanding), 32'd4);
    m_RLAST = 1'b1;
    repeat (4) cyc();
    m_RVALID = 1'b0; m_RLAST = 1'b0;
    check("drain rd_outstanding", 32'(rd_outstanding), 32'd0);
    check("drain err_underflow", 32'(err_underflow), 32'd0);

    // W presented ahead of its AW is held
    s_WVALID = 1'b1; s_WLAST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("w early%0d m_WVALID", i), 32'(m_WVALID), 32'd0);
      check($sformatf("w early%0d s_WREADY", i), 32'(s_WREADY), 32'd0);
      cyc();
    end
    s_AWVALID = 1'b1; s_AWLEN = 8'd3;
    #1;
    check("aw hs m_AWVALID", 32'(m_AWVALID), 32'd1);
    check("aw hs-cycle m_WVALID", 32'(m_WVALID), 32'd0);
    check("aw m_AWLEN passthru", 32'(m_AWLEN), 32'd3);
    cyc();
    s_AWVALID = 1'b0;
    check("aw wr_outstanding", 32'(wr_outstanding), 32'd1);
    for (int k = 0; k < 4; k++) begin
      s_WLAST = (k == 3);
      #1;
      check($sformatf("w beat%0d m_WVALID", k), 32'(m_WVALID), 32'd1);
      cyc();
    end
    s_WLAST = 1'b0;
    #1;
    check("w credit0 m_WVALID", 32'(m_WVALID), 32'd0);
    s_WVALID = 1'b0;
    m_BVALID = 1'b1;
    #1;
    check("b s_BVALID passthru", 32'(s_BVALID), 32'd1);
    cyc();
    m_BVALID = 1'b0;
    check("b wr_outstanding", 32'(wr_outstanding), 32'd0);

    // WLAST coincides with third AW handshake
    s_AWVALID = 1'b1; s_AWLEN = 8'd1;
    cyc(); cyc();
    s_AWVALID = 1'b0;
    check("2aw wr_outstanding", 32'(wr_outstanding), 32'd2);
    s_WVALID = 1'b1; s_WLAST = 1'b0;
    cyc();
    s_WLAST = 1'b1; s_AWVALID = 1'b1;
    #1;
    check("coinc m_AWVALID", 32'(m_AWVALID), 32'd1);
    check("coinc m_WVALID", 32'(m_WVALID), 32'd1);
    cyc();
    s_AWVALID = 1'b0;
    check("coinc wr_outstanding", 32'(wr_outstanding), 32'd3);
    for (int k = 0; k < 4; k++) begin
      s_WLAST = (k % 2) == 1;
      #1;
      check($sformatf("credit2 beat%0d m_WVALID", k), 32'(m_WVALID), 32'd1);
      cyc();
    end
    s_WLAST = 1'b0;
    #1;
    check("credit exhausted m_WVALID", 32'(m_WVALID), 32'd0);
    s_WVALID = 1'b0;
    m_BVALID = 1'b1;
    repeat (3) cyc();
    m_BVALID = 1'b0;
    check("3b wr_outstanding", 32'(wr_outstanding), 32'd0);
    check("3b err_underflow", 32'(err_underflow), 32'd0);

    // B with nothing outstanding
    m_BVALID = 1'b1;
    cyc();
    m_BVALID = 1'b0;
    check("uflow wr_outstanding", 32'(wr_outstanding), 32'd0);
    check("uflow err_underflow", 32'(err_underflow), 32'd1);
    repeat (3) cyc();
    check("uflow sticky", 32'(err_underflow), 32'd1);

    // reset mid-operation
    s_ARVALID = 1'b1; s_ARLEN = 8'd0;
    repeat (3) cyc();
    s_ARVALID = 1'b0;
    s_AWVALID = 1'b1; s_AWLEN = 8'd0;
    repeat (2) cyc();
    s_AWVALID = 1'b0;
    check("pre-rst rd_outstanding", 32'(rd_outstanding), 32'd3);
    check("pre-rst wr_outstanding", 32'(wr_outstanding), 32'd2);
    ap_rst = 1'b1; s_ARVALID = 1'b1; s_AWVALID = 1'b1; s_WVALID = 1'b1;
    #1;
    check_gated("rst1");
    cyc();
    check("rst1 rd_outstanding", 32'(rd_outstanding), 32'd0);
    check("rst1 wr_outstanding", 32'(wr_outstanding), 32'd0);
    check("rst1 err_underflow", 32'(err_underflow), 32'd0);
    ap_rst = 1'b0; s_AWVALID = 1'b0;
    #1;
    check("post-rst m_WVALID", 32'(m_WVALID), 32'd0);
    check("post-rst s_ARREADY", 32'(s_ARREADY), 32'd1);
    cyc();
    s_ARVALID = 1'b0; s_WVALID = 1'b0;
    check("post-rst rd_outstanding", 32'(rd_outstanding), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
